// File: rtl/lzw_pkg.sv
// lzw_pkg: shared code-width defaults, clog2 helper and packer state encoding
package lzw_pkg;
  localparam int LZW_MIN_CODE_W = 9;
  localparam int LZW_MAX_CODE_W = 12;
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, DONE} pk_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/lzw_byte_fifo.sv
// lzw_byte_fifo: power-of-two FIFO with level count and combinational head
module lzw_byte_fifo import lzw_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge Clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/lzw_code_packer.sv
// lzw_code_packer: packs variable-width LZW codes MSB-first into a byte FIFO with flush
module lzw_code_packer import lzw_pkg::*; #(
  parameter int MAX_CODE_W = LZW_MAX_CODE_W,
  parameter int MIN_CODE_W = LZW_MIN_CODE_W,
  parameter int OUT_W = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int WW = clog2(MAX_CODE_W+1),
  localparam int LW = clog2(FIFO_DEPTH)+1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [MAX_CODE_W-1:0] iCode,
  input  logic [WW-1:0]         iCodeWidth,
  input  logic                  iCodeValid,
  output logic                  oCodeReady,
  input  logic                  iFlush,
  output logic [OUT_W-1:0]      oByte,
  output logic                  oByteValid,
  input  logic                  iByteReady,
  output logic [LW-1:0]         oLevel,
  output logic                  oFlushDone,
  output logic                  oWidthErr
);
  localparam int ACC_W = MAX_CODE_W+OUT_W-1;
  localparam int CW = clog2(ACC_W+1);
  pk_state_t state;
  logic [ACC_W-1:0] acc, code_bits;
  logic [CW-1:0] cnt;
  logic [WW-1:0] w;
  logic [OUT_W-1:0] push_byte;
  logic w_lo, w_hi, accept, extract, pad, push, fifo_pop, fifo_full, fifo_empty, can_push;
  assign w_lo = iCodeWidth < WW'(MIN_CODE_W);
  assign w_hi = iCodeWidth > WW'(MAX_CODE_W);
  assign w = w_lo ? WW'(MIN_CODE_W) : w_hi ? WW'(MAX_CODE_W) : iCodeWidth;
  assign oCodeReady = Reset_n && state == RUN && cnt < CW'(OUT_W);
  assign accept = iCodeValid && oCodeReady;
  assign fifo_pop = iByteReady && !fifo_empty;
  assign can_push = !fifo_full || fifo_pop;
  assign extract = (state == RUN || state == FLUSH) && cnt >= CW'(OUT_W) && can_push;
  assign pad = state == FLUSH && cnt != '0 && cnt < CW'(OUT_W) && can_push;
  assign push = extract || pad;
  assign code_bits = ACC_W'(iCode) & ~({ACC_W{1'b1}} << w);
  // acc keeps the valid bits right-aligned in acc[cnt-1:0]; bits above are stale
  assign push_byte = pad ? OUT_W'(acc << (CW'(OUT_W) - cnt)) : OUT_W'(acc >> (cnt - CW'(OUT_W)));
  assign oByteValid = !fifo_empty;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= RUN;
      acc <= '0;
      cnt <= '0;
      oFlushDone <= 1'b0;
      oWidthErr <= 1'b0;
    end else begin
      oFlushDone <= 1'b0;
      if (accept) begin
        acc <= (acc << w) | code_bits;
        cnt <= cnt + CW'(w);
        if (w_lo || w_hi) oWidthErr <= 1'b1;
      end else if (extract) cnt <= cnt - CW'(OUT_W);
      else if (pad) cnt <= '0;
      case (state)
        RUN: if (iFlush) state <= FLUSH;
        FLUSH: if (cnt == '0) state <= DRAIN;
        DRAIN: if (fifo_empty) begin
          state <= DONE;
          oFlushDone <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  lzw_byte_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .push(push),
    .din(push_byte),
    .pop(fifo_pop),
    .dout(oByte),
    .full(fifo_full),
    .empty(fifo_empty),
    .level(oLevel)
  );
endmodule
